// File: rtl/timer_int.sv
// Memory-mapped compare timer raising one level interrupt line on int_sig_o[INT_BIT].
// Optional PRESC register and tick divider are built when TIMER_PRESCALER_EN is defined.
module timer_int #(
   parameter int INT_BIT = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic [7:0]  int_sig_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        ie_q, ie_d;
   logic        pend_q, pend_d;
   logic        per_q, per_d;
   logic [31:0] count_q, count_d;
   logic [31:0] value_q, value_d;
   logic        tick;
   logic        expire;
   logic        wr_ctrl, wr_count, wr_value;
   logic [27:0] unused_addr;

   assign unused_addr = addr_i[31:4];
   assign wr_ctrl     = we_i && (addr_i[3:0] == 4'h0);
   assign wr_count    = we_i && (addr_i[3:0] == 4'h4);
   assign wr_value    = we_i && (addr_i[3:0] == 4'h8);

`ifdef TIMER_PRESCALER_EN
   logic [15:0] presc_q, presc_d;
   logic [15:0] div_q, div_d;
   logic        wr_presc;

   assign wr_presc = we_i && (addr_i[3:0] == 4'hC);
   assign tick     = (state_q == S_RUN) && (div_q == presc_q);

   always_comb begin
      presc_d = presc_q;
      div_d   = 16'd0;
      if (state_q == S_RUN) div_d = tick ? 16'd0 : div_q + 16'd1;
      if (wr_presc) begin
         presc_d = data_i[15:0];
         div_d   = 16'd0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc_q <= 16'd0;
         div_q   <= 16'd0;
      end else begin
         presc_q <= presc_d;
         div_q   <= div_d;
      end
   end
`else
   assign tick = (state_q == S_RUN);
`endif

   assign expire = tick && (count_q >= value_q);

   // Ordering matters: W1C of PEND loses to a same-cycle expiry, while a
   // software write of EN overrides the one-shot auto-stop.
   always_comb begin
      state_d = state_q;
      ie_d    = ie_q;
      pend_d  = pend_q;
      per_d   = per_q;
      count_d = count_q;
      value_d = value_q;
      if (tick) count_d = expire ? 32'd0 : count_q + 32'd1;
      if (wr_ctrl && data_i[2]) pend_d = 1'b0;
      if (expire) begin
         pend_d = 1'b1;
         if (!per_q) state_d = S_IDLE;
      end
      if (wr_ctrl) begin
         state_d = data_i[0] ? S_RUN : S_IDLE;
         ie_d    = data_i[1];
         per_d   = data_i[3];
      end
      if (wr_count) count_d = data_i;
      if (wr_value) value_d = data_i;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         ie_q    <= 1'b0;
         pend_q  <= 1'b0;
         per_q   <= 1'b0;
         count_q <= 32'd0;
         value_q <= 32'd0;
      end else begin
         state_q <= state_d;
         ie_q    <= ie_d;
         pend_q  <= pend_d;
         per_q   <= per_d;
         count_q <= count_d;
         value_q <= value_d;
      end
   end

   always_comb begin
      data_o = 32'd0;
      case (addr_i[3:0])
         4'h0: data_o = {28'd0, per_q, pend_q, ie_q, (state_q == S_RUN)};
         4'h4: data_o = count_q;
         4'h8: data_o = value_q;
`ifdef TIMER_PRESCALER_EN
         4'hC: data_o = {16'd0, presc_q};
`endif
         default: data_o = 32'd0;
      endcase
   end

   always_comb begin
      int_sig_o          = 8'd0;
      int_sig_o[INT_BIT] = pend_q & ie_q;
   end

endmodule

// File: tb/tb_timer_int.sv
// Directed bench for timer_int: register access, one-shot/periodic expiry,
// same-cycle priority cases and asynchronous reset.
module tb_timer_int;

   logic        clk;
   logic        rstn;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [7:0]  int_sig_o;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] rd_v;
   logic [31:0] exp_q[$];

   timer_int #(.INT_BIT(0)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .data_i    (data_i),
      .data_o    (data_o),
      .int_sig_o (int_sig_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no summary, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // All driver tasks are entered and left on a falling edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      we_i   = 1'b1;
      addr_i = a;
      data_i = d;
      @(negedge clk);
      we_i   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr_i = a;
      #1;
      d = data_o;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
      rd(a, rd_v);
      check_eq(tag, rd_v, exp);
   endtask

   initial begin
      rstn = 1'b0; we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
      step(2);
      chk_reg("rst_ctrl", 32'h0, 32'h0);
      chk_reg("rst_count", 32'h4, 32'h0);
      chk_reg("rst_value", 32'h8, 32'h0);
      check_eq("rst_int", {24'd0, int_sig_o}, 32'h0);
      rstn = 1'b1;
      step(1);

      // One-shot VALUE=3: COUNT 1,2,3,0 then stop with PEND.
      wr(32'h8, 32'd3);
      wr(32'h0, 32'h3);
      chk_reg("os_ctrl_run", 32'h0, 32'h3);
      exp_q = '{32'd1, 32'd2, 32'd3, 32'd0};
      while (exp_q.size() > 0) begin
         step(1);
         chk_reg("os_count", 32'h4, exp_q.pop_front());
      end
      chk_reg("os_ctrl_done", 32'h0, 32'h6);
      check_eq("os_int", {24'd0, int_sig_o}, 32'h1);
      chk_reg("unmapped_2", 32'h2, 32'h0);
      step(2);
      chk_reg("os_idle_hold", 32'h4, 32'h0);
      wr(32'h0, 32'h4);
      chk_reg("os_clear", 32'h0, 32'h0);
      check_eq("os_int_clear", {24'd0, int_sig_o}, 32'h0);

      // Periodic VALUE=2: PEND every 3 ticks, W1C while running.
      wr(32'h8, 32'd2);
      wr(32'h0, 32'hB);
      step(3);
      chk_reg("per_ctrl_pend", 32'h0, 32'hF);
      chk_reg("per_count0", 32'h4, 32'h0);
      check_eq("per_int", {24'd0, int_sig_o}, 32'h1);
      wr(32'h0, 32'hF);
      chk_reg("per_w1c_ctrl", 32'h0, 32'hB);
      check_eq("per_w1c_int", {24'd0, int_sig_o}, 32'h0);
      chk_reg("per_keeps_run", 32'h4, 32'h1);
      step(2);
      chk_reg("per_repend", 32'h0, 32'hF);

      // W1C landing exactly on the expiry edge: set wins.
      wr(32'h0, 32'hF);
      wr(32'h0, 32'hF);
      chk_reg("race_pre", 32'h0, 32'hB);
      chk_reg("race_pre_cnt", 32'h4, 32'h2);
      wr(32'h0, 32'hF);
      chk_reg("race_w1c_pend", 32'h0, 32'hF);
      check_eq("race_w1c_int", {24'd0, int_sig_o}, 32'h1);
      wr(32'h0, 32'h4);
      chk_reg("race_stop", 32'h0, 32'h0);

      // EN=0 write in the one-shot expiry cycle: IDLE with PEND.
      wr(32'h4, 32'd0);
      wr(32'h8, 32'd1);
      wr(32'h0, 32'h3);
      step(1);
      wr(32'h0, 32'h2);
      chk_reg("en0_expiry_ctrl", 32'h0, 32'h6);
      chk_reg("en0_expiry_cnt", 32'h4, 32'h0);
      wr(32'h0, 32'h4);

      // COUNT write on a tick wins; clearing EN keeps COUNT.
      wr(32'h8, 32'd100);
      wr(32'h0, 32'h1);
      step(2);
      chk_reg("cnt_run", 32'h4, 32'd2);
      wr(32'h4, 32'd50);
      chk_reg("cnt_write_wins", 32'h4, 32'd50);
      step(1);
      chk_reg("cnt_after_write", 32'h4, 32'd51);
      wr(32'h0, 32'h0);
      chk_reg("cnt_stop", 32'h4, 32'd52);
      step(3);
      chk_reg("cnt_idle_hold", 32'h4, 32'd52);

      // VALUE=0 with IE=0: PEND every tick, no interrupt until IE set.
      wr(32'h4, 32'd0);
      wr(32'h8, 32'd0);
      wr(32'h0, 32'h9);
      step(1);
      chk_reg("v0_ctrl", 32'h0, 32'hD);
      check_eq("v0_int_masked", {24'd0, int_sig_o}, 32'h0);
      wr(32'h0, 32'hB);
      check_eq("v0_int_ie", {24'd0, int_sig_o}, 32'h1);
      step(2);
      chk_reg("v0_count_stays0", 32'h4, 32'h0);
      wr(32'h0, 32'h4);
      chk_reg("v0_stop_pend_set", 32'h0, 32'h4);
      wr(32'h0, 32'h4);
      chk_reg("v0_cleared", 32'h0, 32'h0);

`ifdef TIMER_PRESCALER_EN
      wr(32'h4, 32'd0);
      wr(32'h8, 32'd1);
      wr(32'hC, 32'd4);
      chk_reg("presc_rd", 32'hC, 32'd4);
      wr(32'h0, 32'h3);
      step(4);
      chk_reg("presc_c4", 32'h4, 32'd0);
      step(1);
      chk_reg("presc_c5", 32'h4, 32'd1);
      step(4);
      chk_reg("presc_c9", 32'h0, 32'h3);
      step(1);
      chk_reg("presc_c10", 32'h0, 32'h6);
      wr(32'h0, 32'h4);
      wr(32'hC, 32'd0);
`else
      wr(32'hC, 32'hFFFF);
      chk_reg("presc_absent", 32'hC, 32'h0);
`endif

      // Asynchronous reset in the middle of a periodic count.
      wr(32'h4, 32'd0);
      wr(32'h8, 32'd2);
      wr(32'h0, 32'hB);
      step(3);
      wr(32'h8, 32'd100);
      step(4);
      chk_reg("ar_pre_count", 32'h4, 32'd5);
      check_eq("ar_pre_int", {24'd0, int_sig_o}, 32'h1);
      #1 rstn = 1'b0;
      #1;
      check_eq("ar_int_async", {24'd0, int_sig_o}, 32'h0);
      chk_reg("ar_ctrl", 32'h0, 32'h0);
      chk_reg("ar_count", 32'h4, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      step(5);
      chk_reg("ar_no_ticks", 32'h4, 32'h0);
      chk_reg("ar_value", 32'h8, 32'h0);
      check_eq("ar_int_after", {24'd0, int_sig_o}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
